// File: rtl/dreimann_uart_tx_if.sv
// Byte push port of the DreiMann UART transmitter.
// Valid/ready handshake carrying one byte per accepted transfer.
interface dreimann_uart_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/dreimann_uart_tx.sv
// DreiMann event UART transmitter: byte FIFO feeding a
// start/data/parity/stop serialiser on a single line.
module dreimann_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  dreimann_uart_tx_if.slave             in_if,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_end;
  logic [7:0] head;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign push     = in_if.in_valid && !full;
  assign head     = mem_q[rd_q];
  assign baud_end = (baud_q == BAUD_LAST);

  assign in_if.in_ready = !full;
  assign fifo_cnt       = cnt_q;
  assign busy           = (state_q != S_IDLE) || !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        pop    = !empty;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            pop     = !empty;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop always launches a fresh frame, also straight out of STOP
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      byte_d  = head;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
      S_PARITY: tx = ^byte_q ^ ODD_BIT;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_if.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      byte_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dreimann_uart_tx.sv
// Bench for dreimann_uart_tx: a line-level UART frame decoder
// and accepted-byte scoreboard check two parameterisations.
module tb_dreimann_uart_tx;
  localparam int CPB = 4;
  localparam int FL0 = 10 * CPB;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic [2:0] cnt;
    logic       rdy;
  } smp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dreimann_uart_tx_if if0();
  dreimann_uart_tx_if if1();

  logic       tx0, busy0, tx1, busy1;
  logic [2:0] cnt0, cnt1;

  dreimann_uart_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .in_if(if0),
    .tx(tx0), .busy(busy0), .fifo_cnt(cnt0)
  );

  dreimann_uart_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .in_if(if1),
    .tx(tx1), .busy(busy1), .fifo_cnt(cnt1)
  );

  smp_t       tr0[$];
  smp_t       tr1[$];
  logic [7:0] sb0[$];
  logic [7:0] rx0[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    logic a0;
    logic [7:0] d0;
    smp_t s;
    a0 = if0.in_valid && if0.in_ready;
    d0 = if0.in_data;
    @(posedge clk);
    #1;
    if (rst) sb0.delete();
    else if (a0) sb0.push_back(d0);
    s = '{tx0, busy0, cnt0, if0.in_ready};
    tr0.push_back(s);
    s = '{tx1, busy1, cnt1, if1.in_ready};
    tr1.push_back(s);
  endtask

  // Decode one frame from the recorded line starting at index s
  function automatic bit frame_at(input bit which, input int s,
                                  input int pe, input int po,
                                  input int sb, output logic [7:0] b);
    int  len;
    int  k;
    bit  ok;
    logic v;
    logic e;
    len = (10 + pe + sb - 1) * CPB;
    ok  = 1'b1;
    b   = '0;
    for (int c = 0; c < len; c++) begin
      if (which ? (s + c >= tr1.size()) : (s + c >= tr0.size()))
        return 1'b0;
      v = which ? tr1[s+c].tx : tr0[s+c].tx;
      k = c / CPB;
      if (k >= 1 && k <= 8 && (c % CPB) == 0) b[k-1] = v;
      if (k == 0)                e = 1'b0;
      else if (k <= 8)           e = b[k-1];
      else if (pe != 0 && k == 9) e = ^b ^ po[0];
      else                       e = 1'b1;
      if (v !== e) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic decode_stream(output int bad);
    int i;
    logic [7:0] b;
    rx0.delete();
    bad = 0;
    i = 0;
    while (i < tr0.size()) begin
      if (tr0[i].tx === 1'b0) begin
        if (frame_at(1'b0, i, 0, 0, 1, b)) rx0.push_back(b);
        else bad++;
        i += FL0;
      end else begin
        i++;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit timeout);
    int n;
    n = 0;
    while (!(busy0 === 1'b0 && tx0 === 1'b1 &&
             busy1 === 1'b0 && tx1 === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    timeout = (n >= budget);
  endtask

  task automatic test_reset();
    smp_t s;
    rst = 1'b1;
    if0.in_valid = 1'b0;
    if0.in_data  = '0;
    if1.in_valid = 1'b0;
    if1.in_data  = '0;
    tick();
    tick();
    for (int w = 0; w < 2; w++) begin
      s = (w == 0) ? tr0[$] : tr1[$];
      checks++;
      if (s.tx !== 1'b1) begin
        errors++;
        $display("FAIL reset_tx%0d got %b want 1", w, s.tx);
      end
      checks++;
      if (s.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy%0d got %b want 0", w, s.busy);
      end
      checks++;
      if (s.cnt !== 3'd0) begin
        errors++;
        $display("FAIL reset_cnt%0d got %0d want 0", w, s.cnt);
      end
      checks++;
      if (s.rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready%0d got %b want 1", w, s.rdy);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [9:0] line;
    bit bad;
    line = {1'b1, 8'hA5, 1'b0};
    tr0.delete();
    if0.in_valid = 1'b1;
    if0.in_data  = 8'hA5;
    tick();
    if0.in_valid = 1'b0;
    if0.in_data  = 8'($urandom);
    repeat (41) tick();
    checks++;
    if (tr0[0].tx !== 1'b1 || tr0[0].cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_accept tx=%b cnt=%0d want tx=1 cnt=1",
               tr0[0].tx, tr0[0].cnt);
    end
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      for (int j = 0; j < CPB; j++)
        if (tr0[1 + k*CPB + j].tx !== line[k]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL single_bit%0d got %b want %b",
                 k, tr0[1 + k*CPB].tx, line[k]);
      end
    end
    checks++;
    if (tr0[40].busy !== 1'b1 || tr0[41].busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy got %b%b want 10",
               tr0[40].busy, tr0[41].busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    logic [7:0] b;
    int  peak;
    bit  to;
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h3C;
    tr0.delete();
    for (int i = 0; i < 3; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = pat[i];
      tick();
    end
    if0.in_valid = 1'b0;
    wait_idle(300, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_idle timeout busy=%b want 0", busy0);
    end
    peak = 0;
    foreach (tr0[i]) if (int'(tr0[i].cnt) > peak) peak = int'(tr0[i].cnt);
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL b2b_peak got %0d want 2", peak);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!frame_at(1'b0, 1 + i*FL0, 0, 0, 1, b) || b !== pat[i]) begin
        errors++;
        $display("FAIL b2b_frame%0d got %h want %h", i, b, pat[i]);
      end
    end
    checks++;
    if (tr0.size() < 122 || tr0[120].busy !== 1'b1 ||
        tr0[121].busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_len size=%0d want busy 1 at 120, 0 at 121",
               tr0.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d [6];
    logic [7:0] base;
    int  k;
    int  nfull;
    int  bad;
    bit  to;
    bit  ok;
    base = 8'($urandom);
    for (int i = 0; i < 6; i++) d[i] = base + 8'(i * 37);
    tr0.delete();
    sb0.delete();
    for (int t = 0; t < 12; t++) begin
      k = (sb0.size() < 6) ? sb0.size() : 5;
      if0.in_valid = 1'b1;
      if0.in_data  = d[k];
      tick();
    end
    if0.in_valid = 1'b0;
    checks++;
    if (sb0.size() != 5) begin
      errors++;
      $display("FAIL full_accepts got %0d want 5", sb0.size());
    end
    nfull = 0;
    ok = 1'b1;
    foreach (tr0[i]) if (tr0[i].cnt == 3'd4) begin
      nfull++;
      if (tr0[i].rdy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (nfull == 0 || !ok) begin
      errors++;
      $display("FAIL full_ready full_cycles=%0d ready_ok=%b want >0,1",
               nfull, ok);
    end
    wait_idle(400, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL full_idle timeout busy=%b want 0", busy0);
    end
    decode_stream(bad);
    checks++;
    if (bad != 0 || rx0.size() != 5) begin
      errors++;
      $display("FAIL full_frames got %0d (bad %0d) want 5",
               rx0.size(), bad);
    end
    for (int i = 0; i < 5 && i < rx0.size(); i++) begin
      checks++;
      if (rx0[i] !== d[i]) begin
        errors++;
        $display("FAIL full_byte%0d got %h want %h", i, rx0[i], d[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    bit to;
    tr1.delete();
    if1.in_valid = 1'b1;
    if1.in_data  = 8'h07;
    tick();
    if1.in_valid = 1'b0;
    wait_idle(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL parity_idle timeout busy=%b want 0", busy1);
    end
    checks++;
    if (!frame_at(1'b1, 1, 1, 1, 2, b) || b !== 8'h07) begin
      errors++;
      $display("FAIL parity_frame got %h want 07", b);
    end
    checks++;
    if (tr1[1 + 9*CPB].tx !== 1'b0) begin
      errors++;
      $display("FAIL parity_bit got %b want 0", tr1[1 + 9*CPB].tx);
    end
    checks++;
    if (tr1.size() < 50 || tr1[48].busy !== 1'b1 ||
        tr1[49].busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_len size=%0d want busy 1 at 48, 0 at 49",
               tr1.size());
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    tr0.delete();
    for (int i = 0; i < 3; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 8'($urandom);
      tick();
    end
    if0.in_valid = 1'b0;
    while (tr0.size() < 55) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_tx got %b want 1", tx0);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy got %b want 0", busy0);
    end
    checks++;
    if (cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_cnt got %0d want 0", cnt0);
    end
    tr0.delete();
    repeat (100) tick();
    quiet = 1'b1;
    foreach (tr0[i]) if (tr0[i].tx !== 1'b1 || tr0[i].busy !== 1'b0)
      quiet = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL rstmid_quiet got activity want idle line");
    end
  endtask

  task automatic test_last_stop();
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    tr0.delete();
    if0.in_valid = 1'b1;
    if0.in_data  = b1;
    tick();
    if0.in_valid = 1'b0;
    repeat (40) tick();
    if0.in_valid = 1'b1;
    if0.in_data  = b2;
    tick();
    if0.in_valid = 1'b0;
    repeat (45) tick();
    checks++;
    if (tr0[41].tx !== 1'b1 || tr0[41].cnt !== 3'd1) begin
      errors++;
      $display("FAIL laststop_gap tx=%b cnt=%0d want tx=1 cnt=1",
               tr0[41].tx, tr0[41].cnt);
    end
    checks++;
    if (tr0[42].tx !== 1'b0) begin
      errors++;
      $display("FAIL laststop_start got %b want 0", tr0[42].tx);
    end
    checks++;
    if (!frame_at(1'b0, 1, 0, 0, 1, b) || b !== b1) begin
      errors++;
      $display("FAIL laststop_frame1 got %h want %h", b, b1);
    end
    checks++;
    if (!frame_at(1'b0, 42, 0, 0, 1, b) || b !== b2) begin
      errors++;
      $display("FAIL laststop_frame2 got %h want %h", b, b2);
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    bit to;
    tr0.delete();
    sb0.delete();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if0.in_valid = 1'b1;
      if0.in_data  = 8'($urandom);
      n = 0;
      while (sb0.size() < i + 1 && n < 200) begin
        tick();
        n++;
      end
      if0.in_valid = 1'b0;
      if0.in_data  = 8'($urandom);
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL rand_accept%0d timeout ready=%b want 1",
                 i, if0.in_ready);
      end
    end
    wait_idle(1200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rand_idle timeout busy=%b want 0", busy0);
    end
    decode_stream(bad);
    checks++;
    if (bad != 0 || rx0.size() != sb0.size()) begin
      errors++;
      $display("FAIL rand_count got %0d (bad %0d) want %0d",
               rx0.size(), bad, sb0.size());
    end
    for (int i = 0; i < sb0.size() && i < rx0.size(); i++) begin
      checks++;
      if (rx0[i] !== sb0[i]) begin
        errors++;
        $display("FAIL rand_byte%0d got %h want %h", i, rx0[i], sb0[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_reset_mid();
    test_last_stop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
